// File: rtl/add_seq_pkg.sv
// Shared definitions for the sliced wide-add sequencer: slice width, FSM states and slice count.
package add_seq_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } add_seq_state_t;

  function automatic int unsigned nslice(input int unsigned width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/ripple.sv
// 4-bit ripple-carry adder slice shared by the wide-add sequencer.
module ripple
  import add_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] a_i,
  input  logic [SLICE_W-1:0] b_i,
  input  logic               cin_i,
  output logic [SLICE_W-1:0] sum_o,
  output logic               cout_o
);

  always_comb begin
    logic carry;
    carry = cin_i;
    sum_o = '0;
    for (int i = 0; i < SLICE_W; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
      carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
    end
    cout_o = carry;
  end

endmodule

// File: rtl/wide_add_sequencer.sv
// Arbitrates two requesters and sequences a WIDTH-bit add over one 4-bit ripple slice,
// one slice per cycle LSB first, with the carry registered between slices.
module wide_add_sequencer
  import add_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  input  logic [1:0]         req_cin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_sum,
  output logic               out_cout,
  output logic               out_id,
  output logic               busy
);

  localparam int unsigned NSLICE = nslice(WIDTH);
  localparam int unsigned IDX_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  add_seq_state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic carry_q, carry_d;
  logic cout_q, cout_d;
  logic id_q, id_d;
  logic last_grant_q, last_grant_d;
  logic grant;

  logic [SLICE_W-1:0] slice_a, slice_b, slice_sum;
  logic               slice_cout;

  // Round-robin on a tie: the requester not served last wins.
  assign grant = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];

  always_comb begin
    slice_a = a_q[idx_q*SLICE_W +: SLICE_W];
    slice_b = b_q[idx_q*SLICE_W +: SLICE_W];
  end

  ripple u_ripple (
    .a_i   (slice_a),
    .b_i   (slice_b),
    .cin_i (carry_q),
    .sum_o (slice_sum),
    .cout_o(slice_cout)
  );

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    sum_d        = sum_q;
    idx_d        = idx_q;
    carry_d      = carry_q;
    cout_d       = cout_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    req_ready    = 2'b00;

    unique case (state_q)
      IDLE: begin
        // Gated by rst_n so req_ready reads 0 while reset is asserted.
        if (rst_n && (req_valid != 2'b00)) begin
          req_ready[grant] = 1'b1;
          a_d     = grant ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
          b_d     = grant ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
          carry_d = req_cin[grant];
          idx_d   = '0;
          id_d    = grant;
          state_d = ADD;
        end
      end
      ADD: begin
        sum_d[idx_q*SLICE_W +: SLICE_W] = slice_sum;
        carry_d = slice_cout;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          cout_d  = slice_cout;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          last_grant_d = id_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      sum_q        <= '0;
      idx_q        <= '0;
      carry_q      <= 1'b0;
      cout_q       <= 1'b0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sum_q        <= sum_d;
      idx_q        <= idx_d;
      carry_q      <= carry_d;
      cout_q       <= cout_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_id    = id_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench for wide_add_sequencer: transaction-level model plus directed and random traffic.
module tb_wide_add_sequencer;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned NSLICE = WIDTH / 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [1:0]         req_valid = 2'b00;
  logic [1:0]         req_ready;
  logic [2*WIDTH-1:0] req_a = '0;
  logic [2*WIDTH-1:0] req_b = '0;
  logic [1:0]         req_cin = 2'b00;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [WIDTH-1:0]   out_sum;
  logic               out_cout;
  logic               out_id;
  logic               busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wide_add_sequencer #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .req_cin  (req_cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout),
    .out_id   (out_id),
    .busy     (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: expected event never occurred (t=%0t)", name, $time);
  endtask

  // Transaction-level model: one add in flight, result visible NSLICE edges after accept.
  logic           m_busy;
  int             m_cnt;
  logic           m_last;
  logic [WIDTH-1:0] m_sum;
  logic           m_cout;
  logic           m_id;
  logic           m_g;
  logic [WIDTH:0] m_full;

  assign m_g = (req_valid == 2'b11) ? ~m_last : req_valid[1];
  assign m_full = {1'b0, (m_g ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0])}
                + {1'b0, (m_g ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0])}
                + {{WIDTH{1'b0}}, req_cin[m_g]};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
      m_last <= 1'b1;
      m_sum  <= '0;
      m_cout <= 1'b0;
      m_id   <= 1'b0;
    end else if (!m_busy) begin
      if (req_valid != 2'b00) begin
        m_busy <= 1'b1;
        m_cnt  <= 0;
        m_sum  <= m_full[WIDTH-1:0];
        m_cout <= m_full[WIDTH];
        m_id   <= m_g;
      end
    end else if (m_cnt < int'(NSLICE)) begin
      m_cnt <= m_cnt + 1;
    end else if (out_ready) begin
      m_busy <= 1'b0;
      m_last <= m_id;
    end
  end

  // Compare process, sampled mid-cycle.
  always @(negedge clk) begin
    logic [1:0] exp_ready;
    logic       exp_valid;
    if (!rst_n) begin
      check("reset_out_valid", out_valid, 0);
      check("reset_busy", busy, 0);
      check("reset_req_ready", req_ready, 0);
    end else begin
      exp_ready = (!m_busy && req_valid != 2'b00) ? (2'b01 << m_g) : 2'b00;
      exp_valid = m_busy && (m_cnt == int'(NSLICE));
      check("req_ready", req_ready, exp_ready);
      check("busy", busy, m_busy);
      check("out_valid", out_valid, exp_valid);
      if (exp_valid) begin
        check("out_sum", out_sum, m_sum);
        check("out_cout", out_cout, m_cout);
        check("out_id", out_id, m_id);
      end
    end
  end

  task automatic wait_accept(input int id, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready[id]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle();
    bit seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) timeout("drain_to_idle");
  endtask

  // Single directed add with literal expectations; caller is in IDLE just after a posedge.
  task automatic run_one(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic cin, input logic [WIDTH-1:0] exp_sum, input logic exp_cout);
    bit ok;
    int lat;
    req_valid[id] = 1'b1;
    req_a[id*WIDTH +: WIDTH] = a;
    req_b[id*WIDTH +: WIDTH] = b;
    req_cin[id] = cin;
    out_ready = 1'b1;
    wait_accept(id, ok);
    if (!ok) begin
      timeout("accept");
      req_valid[id] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid[id] = 1'b0;
    req_a[id*WIDTH +: WIDTH] = WIDTH'($urandom);
    req_b[id*WIDTH +: WIDTH] = WIDTH'($urandom);
    req_cin[id] = ~cin;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
      if (out_valid) break;
    end
    check("latency", lat, 4);
    check("dir_sum", out_sum, exp_sum);
    check("dir_cout", out_cout, exp_cout);
    check("dir_id", out_id, id);
    @(posedge clk);
    #1;
    check("dir_done_drop", out_valid, 0);
  endtask

  initial begin
    bit ok;
    int got[$];
    int rem[2];
    logic [1:0] acc;
    int exp_order[4];

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_sum", out_sum, 0);
    check("rst_cout", out_cout, 0);
    check("rst_id", out_id, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed adds
    run_one(0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);
    run_one(1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    run_one(0, 16'h7FFF, 16'h8000, 1'b1, 16'h0000, 1'b1);

    // Both valid from reset: service order alternates starting at 0
    rst_n = 1'b0;
    req_valid = 2'b11;
    req_a = {16'h1111, 16'h2222};
    req_b = {16'h0F0F, 16'hF0F0};
    req_cin = 2'b01;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rem[0] = 2;
    rem[1] = 2;
    for (int cyc = 0; cyc < 200 && got.size() < 4; cyc++) begin
      @(negedge clk);
      if (out_valid) got.push_back(int'(out_id));
      acc = req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (acc[i]) begin
          rem[i]--;
          if (rem[i] == 0) req_valid[i] = 1'b0;
          req_a[i*WIDTH +: WIDTH] = WIDTH'($urandom);
          req_b[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        end
      end
    end
    exp_order = '{0, 1, 0, 1};
    if (got.size() < 4) timeout("order_results");
    for (int k = 0; k < got.size() && k < 4; k++) check("service_order", got[k], exp_order[k]);
    req_valid = 2'b00;
    wait_idle();
    @(posedge clk);
    #1;

    // Back-pressure in DONE with another requester waiting
    out_ready = 1'b0;
    req_valid = 2'b10;
    req_a[WIDTH +: WIDTH] = 16'h1234;
    req_b[WIDTH +: WIDTH] = 16'h1111;
    req_cin[1] = 1'b0;
    wait_accept(1, ok);
    if (!ok) timeout("bp_accept");
    @(posedge clk);
    #1;
    req_valid = 2'b01;
    req_a[WIDTH-1:0] = 16'h0001;
    req_b[WIDTH-1:0] = 16'h0002;
    req_cin[0] = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout("bp_valid");
    for (int i = 0; i < 5; i++) begin
      check("bp_valid_hold", out_valid, 1);
      check("bp_sum_hold", out_sum, 16'h2345);
      check("bp_id_hold", out_id, 1);
      check("bp_busy", busy, 1);
      check("bp_ready_low", req_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_complete", out_valid, 0);
    check("bp_next_grant", req_ready, 2'b01);
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    wait_idle();
    @(posedge clk);
    #1;

    // Reset during slice 2 aborts the add
    req_valid = 2'b01;
    req_a[WIDTH-1:0] = 16'h0F0F;
    req_b[WIDTH-1:0] = 16'h0F0F;
    req_cin[0] = 1'b1;
    wait_accept(0, ok);
    if (!ok) timeout("abort_accept");
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_idle", busy, 0);
    check("abort_no_result", out_valid, 0);
    @(posedge clk);
    #1;
    run_one(0, 16'h0F0F, 16'h0F0F, 1'b1, 16'h1E1F, 1'b0);

    // Randomized traffic against the model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (acc[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          if ($urandom_range(0, 7) == 0) begin
            req_a[i*WIDTH +: WIDTH] = '1;
            req_b[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 1));
          end else begin
            req_a[i*WIDTH +: WIDTH] = WIDTH'($urandom);
            req_b[i*WIDTH +: WIDTH] = WIDTH'($urandom);
          end
          req_cin[i] = 1'($urandom_range(0, 1));
        end
      end
      out_ready = 1'($urandom_range(0, 1));
    end
    req_valid = 2'b00;
    out_ready = 1'b1;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
